// File: rtl/tick_period_meter.sv
// Measures the spacing between rising edges of a tick stream in clk cycles,
// reports lock once the spacing is stable and flags missing ticks.
module tick_period_meter #(
  parameter logic [15:0] MAX_PERIOD = 16'd65535,
  parameter logic [3:0]  LOCK_COUNT = 4'd3
) (
  input  logic        clk,
  input  logic        en,
  input  logic        tick_in,
  output logic [15:0] period,
  output logic        period_valid,
  output logic        locked,
  output logic        timeout,
  output logic [1:0]  state_dbg,
  output logic [15:0] cnt_dbg
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MEASURE = 2'b01,
    LOCKED  = 2'b10,
    TIMEOUT = 2'b11
  } state_t;

  localparam logic [15:0] CNT_LAST = MAX_PERIOD - 16'd1;

  state_t      r_state, w_state_nxt;
  logic        r_tick_d;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [15:0] r_period, w_period_nxt;
  logic        r_valid, w_valid_nxt;
  logic        r_locked, w_locked_nxt;
  logic        r_timeout, w_timeout_nxt;
  logic [3:0]  r_match, w_match_nxt;

  logic        w_tick_evt;
  logic [16:0] w_cnt_inc;
  logic        w_same;
  logic [3:0]  w_match_run;

  assign w_tick_evt = tick_in & ~r_tick_d;
  assign w_cnt_inc  = {1'b0, r_cnt} + 17'd1;
  // A zero run count means no reference period is held yet.
  assign w_same     = (w_cnt_inc == {1'b0, r_period}) && (r_match != 4'd0);
  assign w_match_run = !w_same                 ? 4'd1 :
                       (r_match >= LOCK_COUNT) ? LOCK_COUNT :
                                                 r_match + 4'd1;

  always_ff @(posedge clk) begin
    if (!en) begin
      r_state   <= IDLE;
      r_tick_d  <= 1'b0;
      r_cnt     <= 16'd0;
      r_period  <= 16'd0;
      r_valid   <= 1'b0;
      r_locked  <= 1'b0;
      r_timeout <= 1'b0;
      r_match   <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_tick_d  <= tick_in;
      r_cnt     <= w_cnt_nxt;
      r_period  <= w_period_nxt;
      r_valid   <= w_valid_nxt;
      r_locked  <= w_locked_nxt;
      r_timeout <= w_timeout_nxt;
      r_match   <= w_match_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_period_nxt  = r_period;
    w_valid_nxt   = 1'b0;
    w_locked_nxt  = r_locked;
    w_timeout_nxt = r_timeout;
    w_match_nxt   = r_match;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = 16'd0;
        if (w_tick_evt) w_state_nxt = MEASURE;
      end
      MEASURE, LOCKED: begin
        if (w_tick_evt) begin
          w_cnt_nxt    = 16'd0;
          w_period_nxt = w_cnt_inc[15:0];
          w_valid_nxt  = 1'b1;
          w_match_nxt  = w_match_run;
          if (r_state == LOCKED && !w_same) begin
            w_state_nxt  = MEASURE;
            w_locked_nxt = 1'b0;
          end else if (w_match_run == LOCK_COUNT) begin
            w_state_nxt  = LOCKED;
            w_locked_nxt = 1'b1;
          end
        end else if (r_cnt == CNT_LAST) begin
          // Counter parks at its last value instead of wrapping.
          w_state_nxt   = TIMEOUT;
          w_timeout_nxt = 1'b1;
          w_locked_nxt  = 1'b0;
          w_match_nxt   = 4'd0;
        end else begin
          w_cnt_nxt = w_cnt_inc[15:0];
        end
      end
      TIMEOUT: begin
        if (w_tick_evt) begin
          w_state_nxt   = MEASURE;
          w_timeout_nxt = 1'b0;
          w_cnt_nxt     = 16'd0;
        end
      end
    endcase
  end

  assign period       = r_period;
  assign period_valid = r_valid;
  assign locked       = r_locked;
  assign timeout      = r_timeout;
  assign state_dbg    = r_state;
  assign cnt_dbg      = r_cnt;

endmodule

// File: tb/tb_tick_period_meter.sv
// Bench for tick_period_meter: a default-parameter instance and a
// MAX_PERIOD=20 instance, driven by a vector table plus corner sequences.
module tb_tick_period_meter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        en_a, tick_a, en_b, tick_b;
  logic [15:0] period_a, cnt_a, period_b, cnt_b;
  logic        valid_a, locked_a, timeout_a, valid_b, locked_b, timeout_b;
  logic [1:0]  state_a, state_b;

  tick_period_meter dut_a (
    .clk(clk), .en(en_a), .tick_in(tick_a),
    .period(period_a), .period_valid(valid_a), .locked(locked_a),
    .timeout(timeout_a), .state_dbg(state_a), .cnt_dbg(cnt_a)
  );

  tick_period_meter #(.MAX_PERIOD(16'd20), .LOCK_COUNT(4'd3)) dut_b (
    .clk(clk), .en(en_b), .tick_in(tick_b),
    .period(period_b), .period_valid(valid_b), .locked(locked_b),
    .timeout(timeout_b), .state_dbg(state_b), .cnt_dbg(cnt_b)
  );

  typedef struct {
    int sel;
    int gap;
    int width;
    int exp_valid;
    int exp_period;
    int exp_locked;
    int exp_state;
  } vec_t;

  vec_t tbl [19];
  int   checks = 0;
  int   failures = 0;
  int   strobes_a = 0;
  int   to_cyc_b = 0;
  int   sel = 0;
  int   last_since = 0;

  logic [15:0] o_period, o_cnt;
  logic        o_valid, o_locked, o_timeout;
  logic [1:0]  o_state;

  always_comb begin
    o_period  = (sel == 0) ? period_a  : period_b;
    o_cnt     = (sel == 0) ? cnt_a     : cnt_b;
    o_valid   = (sel == 0) ? valid_a   : valid_b;
    o_locked  = (sel == 0) ? locked_a  : locked_b;
    o_timeout = (sel == 0) ? timeout_a : timeout_b;
    o_state   = (sel == 0) ? state_a   : state_b;
  end

  always @(negedge clk) begin
    if (valid_a) strobes_a++;
    if (timeout_b) to_cyc_b++;
  end

  function automatic vec_t mk(input int s, input int g, input int w, input int ev,
                              input int ep, input int el, input int es);
    vec_t r;
    r.sel = s; r.gap = g; r.width = w; r.exp_valid = ev;
    r.exp_period = ep; r.exp_locked = el; r.exp_state = es;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tick(input logic v);
    if (sel == 0) tick_a = v;
    else tick_b = v;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_period"}, o_period, 0);
    chk({tag, "_valid"}, o_valid, 0);
    chk({tag, "_locked"}, o_locked, 0);
    chk({tag, "_timeout"}, o_timeout, 0);
    chk({tag, "_state"}, o_state, 0);
    chk({tag, "_cnt"}, o_cnt, 0);
  endtask

  // Places a rising tick edge exactly gap cycles after the previous one,
  // holds tick_in high for width cycles, and checks the result of that edge.
  task automatic do_event(input string tag, input int gap, input int width, input int ev,
                          input int ep, input int el, input int es);
    for (int k = 0; k < gap - 1 - last_since; k++) step();
    set_tick(1'b1);
    step();
    chk({tag, "_valid"}, o_valid, ev);
    chk({tag, "_period"}, o_period, ep);
    chk({tag, "_locked"}, o_locked, el);
    chk({tag, "_state"}, o_state, es);
    chk({tag, "_cnt0"}, o_cnt, 0);
    if (width == 1) set_tick(1'b0);
    step();
    chk({tag, "_valid_next"}, o_valid, 0);
    chk({tag, "_cnt1"}, o_cnt, 1);
    last_since = 1;
    while (last_since < width - 1) begin
      step();
      last_since++;
    end
    set_tick(1'b0);
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      sel = tbl[i].sel;
      do_event($sformatf("row%0d", i), tbl[i].gap, tbl[i].width, tbl[i].exp_valid,
               tbl[i].exp_period, tbl[i].exp_locked, tbl[i].exp_state);
    end
  endtask

  initial begin
    int s0;
    int t0;

    // sel, gap, width, valid, period, locked, state
    tbl[0]  = mk(0, 5,     1, 0, 0,     0, 1);
    tbl[1]  = mk(0, 50000, 1, 1, 50000, 0, 1);
    tbl[2]  = mk(0, 100,   1, 1, 100,   0, 1);
    tbl[3]  = mk(0, 100,   1, 1, 100,   0, 1);
    tbl[4]  = mk(0, 100,   1, 1, 100,   1, 2);
    tbl[5]  = mk(0, 100,   1, 1, 100,   1, 2);
    tbl[6]  = mk(0, 97,    1, 1, 97,    0, 1);
    tbl[7]  = mk(0, 97,    1, 1, 97,    0, 1);
    tbl[8]  = mk(0, 97,    1, 1, 97,    1, 2);
    tbl[9]  = mk(0, 97,    1, 1, 97,    1, 2);
    tbl[10] = mk(0, 40,    5, 1, 40,    0, 1);
    tbl[11] = mk(0, 40,    5, 1, 40,    0, 1);
    tbl[12] = mk(0, 40,    5, 1, 40,    1, 2);
    tbl[13] = mk(0, 40,    5, 1, 40,    1, 2);
    tbl[14] = mk(1, 3,     1, 0, 0,     0, 1);
    tbl[15] = mk(1, 20,    1, 1, 20,    0, 1);
    tbl[16] = mk(1, 20,    1, 1, 20,    0, 1);
    tbl[17] = mk(1, 20,    1, 1, 20,    1, 2);
    tbl[18] = mk(1, 20,    1, 1, 20,    1, 2);

    en_a = 1'b0; en_b = 1'b0; tick_a = 1'b0; tick_b = 1'b0;
    repeat (3) step();
    sel = 0; chk_zero_outputs("rst_a");
    sel = 1; chk_zero_outputs("rst_b");
    en_a = 1'b1; en_b = 1'b1;
    repeat (4) step();
    sel = 0;
    chk("idle_state", o_state, 0);
    chk("idle_cnt", o_cnt, 0);

    last_since = 0;
    run_rows(0, 13);

    // Reset while locked at cnt=30, with a tick edge landing on the reset edge.
    for (int k = last_since; k < 30; k++) step();
    chk("pre_rst_cnt", o_cnt, 30);
    chk("pre_rst_locked", o_locked, 1);
    chk("pre_rst_state", o_state, 2);
    s0 = strobes_a;
    en_a = 1'b0;
    tick_a = 1'b1;
    step();
    chk_zero_outputs("mid_rst");
    en_a = 1'b1;
    step();
    chk("en_rise_state", o_state, 1);
    chk("en_rise_valid", o_valid, 0);
    chk("en_rise_cnt", o_cnt, 0);
    tick_a = 1'b0;
    step();
    chk("en_rise_cnt1", o_cnt, 1);
    chk("no_strobe_after_rst", strobes_a - s0, 0);
    last_since = 1;
    do_event("rst_first", 25, 1, 1, 25, 0, 1);

    // Spacing exactly MAX_PERIOD on the short-timeout instance.
    sel = 1;
    last_since = 0;
    t0 = to_cyc_b;
    run_rows(14, 18);
    chk("no_timeout_at_max", to_cyc_b - t0, 0);

    // Ticks stop after lock: timeout exactly MAX_PERIOD cycles after last edge.
    for (int k = last_since; k < 19; k++) step();
    chk("to_pre_cnt", o_cnt, 19);
    chk("to_pre_timeout", o_timeout, 0);
    chk("to_pre_state", o_state, 2);
    step();
    chk("to_timeout", o_timeout, 1);
    chk("to_locked", o_locked, 0);
    chk("to_state", o_state, 3);
    chk("to_cnt", o_cnt, 19);
    chk("to_period", o_period, 20);
    repeat (5) step();
    chk("to_hold_cnt", o_cnt, 19);
    chk("to_hold_timeout", o_timeout, 1);
    chk("to_hold_state", o_state, 3);
    last_since = 0;
    do_event("to_exit", 2, 1, 0, 20, 0, 1);
    chk("to_exit_timeout", o_timeout, 0);
    do_event("after_to", 10, 1, 1, 10, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tick_period_meter.md
TICK_PERIOD_METER -- requirements
Module: tick_period_meter

Interface
REQ-001 The block SHALL have parameter MAX_PERIOD, default 16'd65535, meaning the largest accepted tick spacing in clk cycles; valid range is 2..65535.
REQ-002 The block SHALL have parameter LOCK_COUNT, default 4'd3, meaning the number of consecutive equal periods required for lock; valid range is 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port en, input, 1 bit: synchronous active-low reset; 0 clears all state on the next clk edge.
REQ-005 The block SHALL have port tick_in, input, 1 bit: tick stream synchronous to clk, for example the output of the team's prescaler.
REQ-006 The block SHALL have port period, output, 16 bits: the last measured tick spacing in clk cycles.
REQ-007 The block SHALL have port period_valid, output, 1 bit: a one-cycle strobe marking each new period value.
REQ-008 The block SHALL have port locked, output, 1 bit: high while the tick spacing is stable.
REQ-009 The block SHALL have port timeout, output, 1 bit: high while no tick has arrived within MAX_PERIOD cycles.
REQ-010 The block SHALL have port state_dbg, output, 2 bits: the current FSM state encoding.
REQ-011 The block SHALL have port cnt_dbg, output, 16 bits: the live value of the cycle counter.

Function
REQ-012 Tick detection SHALL be rising-edge only: tick_evt = tick_in & ~tick_d, where tick_d is tick_in registered. A tick_in held high for several cycles SHALL count as one event. tick_evt SHALL add no extra latency.
REQ-013 The FSM SHALL have four states: IDLE=2'b00, MEASURE=2'b01, LOCKED=2'b10, TIMEOUT=2'b11.
REQ-014 IDLE: cnt holds 0. On tick_evt, the FSM SHALL go to MEASURE with cnt<=0 and SHALL NOT pulse period_valid, because there is no reference tick yet.
REQ-015 In MEASURE and LOCKED without tick_evt, cnt SHALL increment by 1 each cycle.
REQ-016 In MEASURE and LOCKED with tick_evt, the block SHALL load period<=cnt+1, set period_valid<=1 for exactly one cycle, and set cnt<=0.
- With ticks N cycles apart, period SHALL equal N.
- Latency: period and period_valid SHALL be visible the cycle after the tick is sampled.
REQ-017 Match logic: on each measured tick, if cnt+1 equals the previously stored period and at least one period has been stored, match_cnt SHALL increment, saturating at LOCK_COUNT. Otherwise match_cnt SHALL be set to 1, counting the new period as the first of a run.
REQ-018 MEASURE SHALL go to LOCKED on the measured tick that makes match_cnt reach LOCK_COUNT; locked SHALL rise in the same cycle that period_valid pulses.
REQ-019 In LOCKED, a measured period that differs from the stored period SHALL drop the FSM to MEASURE with locked<=0 and match_cnt<=1. The new period SHALL still be output with period_valid.
REQ-020 Timeout: in MEASURE or LOCKED, if cnt == MAX_PERIOD-1 and there is no tick_evt in that cycle, the FSM SHALL go to TIMEOUT, with timeout<=1, locked<=0, match_cnt<=0, and cnt holding at MAX_PERIOD-1 (no wrap).
REQ-021 A tick_evt in the same cycle that cnt == MAX_PERIOD-1 SHALL be treated as a valid measurement with period=MAX_PERIOD, and no timeout SHALL occur.
REQ-022 In TIMEOUT, tick_evt SHALL go to MEASURE with timeout<=0 and cnt<=0, without pulsing period_valid. period SHALL keep its last value throughout TIMEOUT.
REQ-023 cnt arithmetic SHALL be 16-bit. cnt+1 SHALL be computed 17 bits wide and cannot overflow because of the MAX_PERIOD saturation.
REQ-024 state_dbg SHALL equal the FSM state register, and cnt_dbg SHALL equal cnt.

Reset
REQ-025 When en=0 at a clk edge, the block SHALL set: state=IDLE, cnt=0, period=0, period_valid=0, locked=0, timeout=0, match_cnt=0, tick_d=0.
REQ-026 Reset SHALL take priority over tick_evt and over timeout in the same cycle.
REQ-027 A tick_in high during the first cycle after en rises SHALL count as a rising edge.
REQ-028 Reset asserted mid-measurement SHALL discard the partial count, and no period_valid SHALL follow it.

Verification
REQ-029 Single-cycle ticks every 50000 cycles, MAX_PERIOD default -> first tick gives no strobe; then period=50000 with period_valid pulsed per tick; locked=1 after the 3rd measured period; state_dbg=2'b10.
REQ-030 Locked at 100-cycle spacing, then one tick at 97 cycles -> period=97, locked=0, state MEASURE; three more ticks at 97-cycle spacing -> locked=1 again.
REQ-031 MAX_PERIOD=16'd20, ticks stopped after lock -> timeout=1 and locked=0 exactly 20 cycles after the last tick, with cnt_dbg=19 held; next tick -> timeout=0 and no strobe; the following tick -> strobe.
REQ-032 MAX_PERIOD=16'd20, tick at exactly 20-cycle spacing -> period=20, timeout never asserts.
REQ-033 tick_in held high for 5 cycles, repeating every 40 cycles -> one event per pulse; period=40.
REQ-034 en driven to 0 at cnt=30 while locked -> next cycle all outputs 0 and state IDLE; after en returns to 1, the first tick produces no strobe.
